// File: rtl/paint_pkg.sv
// Shared definitions for the paint datapath: direction-pad bit positions and
// the auto-repeat FSM state encoding.
package paint_pkg;

  localparam int DIR_LEFT  = 3;
  localparam int DIR_UP    = 2;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_DOWN  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_t;

endpackage

// File: rtl/move_repeat_fsm.sv
// Hold-to-auto-repeat tracker: turns the sampled direction pad into step events
// (first press, after REPEAT_DELAY ticks, then every REPEAT_RATE ticks).
module move_repeat_fsm
  import paint_pkg::*;
#(
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [3:0] i_dir,
  output logic       o_step
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  rep_state_t       r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_dir_q, w_dir_q_next;
  logic             w_step;
  logic             w_pressed;
  logic             w_changed;

  assign w_pressed = (i_dir != 4'd0);
  assign w_changed = (i_dir != r_dir_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dir_q <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_dir_q <= w_dir_q_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_dir_q_next = r_dir_q;
    w_step       = 1'b0;
    if (i_load) begin
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
    end else if (i_en) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_pressed) begin
            w_step       = 1'b1;
            w_dir_q_next = i_dir;
            w_cnt_next   = '0;
            w_state_next = ST_DELAY;
          end
        end
        ST_DELAY, ST_REPEAT: begin
          if (!w_pressed) begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
          end else if (w_changed) begin
            // A new combination behaves like a fresh press: step now, re-arm the delay.
            w_step       = 1'b1;
            w_dir_q_next = i_dir;
            w_cnt_next   = '0;
            w_state_next = ST_DELAY;
          end else if (r_cnt == ((r_state == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
            w_step       = 1'b1;
            w_cnt_next   = '0;
            w_state_next = ST_REPEAT;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign o_step = w_step;

endmodule

// File: rtl/cursor_mover.sv
// Cursor X/Y register for the paint datapath: steps on repeat-FSM events with
// clamp or wrap at the screen edges, plus a clamped synchronous position load.
module cursor_mover
  import paint_pkg::*;
#(
  parameter int X_W          = 8,
  parameter int Y_W          = 7,
  parameter int X_MAX        = 159,
  parameter int Y_MAX        = 119,
  parameter int X_INIT       = 80,
  parameter int Y_INIT       = 60,
  parameter int STEP         = 1,
  parameter int WRAP         = 0,
  parameter int REPEAT_DELAY = 4,
  parameter int REPEAT_RATE  = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enMove,
  input  logic [3:0]     directions,
  input  logic           load,
  input  logic [X_W-1:0] inX,
  input  logic [Y_W-1:0] inY,
  output logic [X_W-1:0] outX,
  output logic [Y_W-1:0] outY,
  output logic           moved
);

  localparam logic [X_W:0] XS  = (X_W+1)'(STEP);
  localparam logic [X_W:0] XM  = (X_W+1)'(X_MAX);
  localparam logic [X_W:0] XM1 = (X_W+1)'(X_MAX + 1);
  localparam logic [Y_W:0] YS  = (Y_W+1)'(STEP);
  localparam logic [Y_W:0] YM  = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0] YM1 = (Y_W+1)'(Y_MAX + 1);

  logic [X_W-1:0] r_x, w_x_next, w_x_dec, w_x_inc, w_x_ld;
  logic [Y_W-1:0] r_y, w_y_next, w_y_dec, w_y_inc, w_y_ld;
  logic [X_W:0]   w_x_ext, w_x_sum;
  logic [Y_W:0]   w_y_ext, w_y_sum;
  logic           r_moved;
  logic           w_step;

  move_repeat_fsm #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_fsm (
    .clock (clock),
    .reset (reset),
    .i_en  (enMove),
    .i_load(load),
    .i_dir (directions),
    .o_step(w_step)
  );

  // One extra bit keeps pos+STEP and the wrap sums free of overflow.
  assign w_x_ext = {1'b0, r_x};
  assign w_x_sum = w_x_ext + XS;
  assign w_x_dec = (w_x_ext < XS) ? ((WRAP != 0) ? X_W'(w_x_ext + XM1 - XS) : '0)
                                  : X_W'(w_x_ext - XS);
  assign w_x_inc = (w_x_sum > XM) ? ((WRAP != 0) ? X_W'(w_x_sum - XM1) : X_W'(X_MAX))
                                  : X_W'(w_x_sum);
  assign w_x_ld  = (inX > X_W'(X_MAX)) ? X_W'(X_MAX) : inX;

  assign w_y_ext = {1'b0, r_y};
  assign w_y_sum = w_y_ext + YS;
  assign w_y_dec = (w_y_ext < YS) ? ((WRAP != 0) ? Y_W'(w_y_ext + YM1 - YS) : '0)
                                  : Y_W'(w_y_ext - YS);
  assign w_y_inc = (w_y_sum > YM) ? ((WRAP != 0) ? Y_W'(w_y_sum - YM1) : Y_W'(Y_MAX))
                                  : Y_W'(w_y_sum);
  assign w_y_ld  = (inY > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : inY;

  always_comb begin
    w_x_next = r_x;
    w_y_next = r_y;
    if (load) begin
      w_x_next = w_x_ld;
      w_y_next = w_y_ld;
    end else if (w_step) begin
      if (directions[DIR_LEFT])       w_x_next = w_x_dec;
      else if (directions[DIR_RIGHT]) w_x_next = w_x_inc;
      if (directions[DIR_UP])         w_y_next = w_y_dec;
      else if (directions[DIR_DOWN])  w_y_next = w_y_inc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x     <= X_W'(X_INIT);
      r_y     <= Y_W'(Y_INIT);
      r_moved <= 1'b0;
    end else begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_moved <= (w_x_next != r_x) || (w_y_next != r_y);
    end
  end

  assign outX  = r_x;
  assign outY  = r_y;
  assign moved = r_moved;

endmodule

// File: tb/tb_cursor_mover.sv
// Directed table-driven bench for cursor_mover: a clamping instance and a
// wrapping instance share the stimulus; each row carries hand-computed results.
module tb_cursor_mover;

  logic       clock;
  logic       reset;
  logic       enMove;
  logic [3:0] directions;
  logic       load;
  logic [7:0] inX;
  logic [6:0] inY;
  logic [7:0] outX, outX_w;
  logic [6:0] outY, outY_w;
  logic       moved, moved_w;

  int n_vec = 0;
  int n_bad = 0;

  cursor_mover dut (
    .clock(clock), .reset(reset), .enMove(enMove), .directions(directions),
    .load(load), .inX(inX), .inY(inY), .outX(outX), .outY(outY), .moved(moved)
  );

  cursor_mover #(.WRAP(1)) dut_w (
    .clock(clock), .reset(reset), .enMove(enMove), .directions(directions),
    .load(load), .inX(inX), .inY(inY), .outX(outX_w), .outY(outY_w), .moved(moved_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       ld;
    logic       en;
    logic [3:0] dir;
    logic [7:0] ix;
    logic [6:0] iy;
    logic [7:0] ex;
    logic [6:0] ey;
    logic       em;
    logic [7:0] ewx;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic ld, input logic en, input logic [3:0] dir,
                     input logic [7:0] ix, input logic [6:0] iy,
                     input logic [7:0] ex, input logic [6:0] ey, input logic em,
                     input logic [7:0] ewx);
    vec_t v;
    v.ld = ld; v.en = en; v.dir = dir; v.ix = ix; v.iy = iy;
    v.ex = ex; v.ey = ey; v.em = em; v.ewx = ewx;
    tbl.push_back(v);
  endtask

  task automatic apply(input string tag, input logic rst, input logic ld, input logic en,
                       input logic [3:0] dir, input logic [7:0] ix, input logic [6:0] iy,
                       input logic [7:0] ex, input logic [6:0] ey, input logic em,
                       input logic [7:0] ewx);
    reset = rst; load = ld; enMove = en; directions = dir; inX = ix; inY = iy;
    @(posedge clock);
    #1;
    n_vec++;
    $display("%s: rst=%0b ld=%0b en=%0b dir=%b -> x=%0d y=%0d moved=%0b wx=%0d wy=%0d",
             tag, rst, ld, en, dir, outX, outY, moved, outX_w, outY_w);
    if (outX !== ex) begin
      n_bad++; $display("FAIL %s outX got %0d expected %0d", tag, outX, ex);
    end
    if (outY !== ey) begin
      n_bad++; $display("FAIL %s outY got %0d expected %0d", tag, outY, ey);
    end
    if (moved !== em) begin
      n_bad++; $display("FAIL %s moved got %0b expected %0b", tag, moved, em);
    end
    if (outX_w !== ewx) begin
      n_bad++; $display("FAIL %s wrap outX got %0d expected %0d", tag, outX_w, ewx);
    end
    if (outY_w !== ey) begin
      n_bad++; $display("FAIL %s wrap outY got %0d expected %0d", tag, outY_w, ey);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; enMove = 1'b0; directions = 4'd0; inX = '0; inY = '0;

    // ld en dir ix iy | x y moved wrap_x
    // single up tap, then release
    add(0, 1, 4'b0100, 0, 0,   80, 59, 1, 80);
    add(0, 1, 4'b0000, 0, 0,   80, 59, 0, 80);
    // hold right: first step, 4-tick delay, then every 2 ticks, release
    add(0, 1, 4'b0010, 0, 0,   81, 59, 1, 81);
    add(0, 1, 4'b0010, 0, 0,   81, 59, 0, 81);
    add(0, 1, 4'b0010, 0, 0,   81, 59, 0, 81);
    add(0, 1, 4'b0010, 0, 0,   81, 59, 0, 81);
    add(0, 1, 4'b0010, 0, 0,   82, 59, 1, 82);
    add(0, 1, 4'b0010, 0, 0,   82, 59, 0, 82);
    add(0, 1, 4'b0010, 0, 0,   83, 59, 1, 83);
    add(0, 1, 4'b0010, 0, 0,   83, 59, 0, 83);
    add(0, 1, 4'b0010, 0, 0,   84, 59, 1, 84);
    add(0, 1, 4'b0000, 0, 0,   84, 59, 0, 84);
    add(0, 1, 4'b0000, 0, 0,   84, 59, 0, 84);
    // load X=2 then left taps: clamp sticks at 0, wrap goes to 159, 158
    add(1, 0, 4'b0000, 2, 59,   2, 59, 1,   2);
    add(0, 1, 4'b1000, 0, 0,    1, 59, 1,   1);
    add(0, 1, 4'b0000, 0, 0,    1, 59, 0,   1);
    add(0, 1, 4'b1000, 0, 0,    0, 59, 1,   0);
    add(0, 1, 4'b0000, 0, 0,    0, 59, 0,   0);
    add(0, 1, 4'b1000, 0, 0,    0, 59, 0, 159);
    add(0, 1, 4'b0000, 0, 0,    0, 59, 0, 159);
    add(0, 1, 4'b1000, 0, 0,    0, 59, 0, 158);
    add(0, 1, 4'b0000, 0, 0,    0, 59, 0, 158);
    // opposite pairs and a diagonal
    add(1, 0, 4'b0000, 50, 59, 50, 59, 1, 50);
    add(0, 1, 4'b1010, 0, 0,   49, 59, 1, 49);
    add(0, 1, 4'b0000, 0, 0,   49, 59, 0, 49);
    add(0, 1, 4'b0101, 0, 0,   49, 58, 1, 49);
    add(0, 1, 4'b0000, 0, 0,   49, 58, 0, 49);
    add(0, 1, 4'b0011, 0, 0,   50, 59, 1, 50);
    add(0, 1, 4'b0000, 0, 0,   50, 59, 0, 50);
    // direction held with enMove low: nothing moves
    for (int i = 0; i < 10; i++) add(0, 0, 4'b0010, 0, 0, 50, 59, 0, 50);
    // out-of-range load clamps; load beats a same-cycle step; same-value load is silent
    add(1, 0, 4'b0000, 200, 100, 159, 100, 1, 159);
    add(1, 1, 4'b0010, 10, 10,   10, 10, 1, 10);
    add(0, 1, 4'b0000, 0, 0,     10, 10, 0, 10);
    add(1, 0, 4'b0000, 10, 10,   10, 10, 0, 10);

    apply("reset", 1, 0, 0, 4'b0000, 0, 0, 80, 60, 0, 80);
    foreach (tbl[k]) begin
      apply($sformatf("vec%0d", k), 0, tbl[k].ld, tbl[k].en, tbl[k].dir, tbl[k].ix,
            tbl[k].iy, tbl[k].ex, tbl[k].ey, tbl[k].em, tbl[k].ewx);
    end

    // direction change mid-REPEAT steps at once and re-arms the delay
    apply("rep_a", 0, 0, 1, 4'b0010, 0, 0, 11, 10, 1, 11);
    apply("rep_b", 0, 0, 1, 4'b0010, 0, 0, 11, 10, 0, 11);
    apply("rep_c", 0, 0, 1, 4'b0010, 0, 0, 11, 10, 0, 11);
    apply("rep_d", 0, 0, 1, 4'b0010, 0, 0, 11, 10, 0, 11);
    apply("rep_e", 0, 0, 1, 4'b0010, 0, 0, 12, 10, 1, 12);
    apply("rep_f", 0, 0, 1, 4'b0010, 0, 0, 12, 10, 0, 12);
    apply("rep_g", 0, 0, 1, 4'b0010, 0, 0, 13, 10, 1, 13);
    apply("chg_a", 0, 0, 1, 4'b0001, 0, 0, 13, 11, 1, 13);
    apply("chg_b", 0, 0, 1, 4'b0001, 0, 0, 13, 11, 0, 13);
    apply("chg_c", 0, 0, 1, 4'b0001, 0, 0, 13, 11, 0, 13);
    apply("chg_d", 0, 0, 1, 4'b0001, 0, 0, 13, 11, 0, 13);
    apply("chg_e", 0, 0, 1, 4'b0001, 0, 0, 13, 12, 1, 13);
    // reset while in DELAY with the pad still held: held dir is a fresh press afterwards
    apply("rst_a", 0, 0, 1, 4'b0010, 0, 0, 14, 12, 1, 14);
    apply("rst_b", 0, 0, 1, 4'b0010, 0, 0, 14, 12, 0, 14);
    apply("rst_c", 1, 0, 1, 4'b0010, 0, 0, 80, 60, 0, 80);
    apply("rst_d", 0, 0, 1, 4'b0010, 0, 0, 81, 60, 1, 81);
    apply("rst_e", 0, 0, 1, 4'b0010, 0, 0, 81, 60, 0, 81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
